// File: rtl/mesh_term_sink.sv
// Mesh terminal sink: drains one router terminal FIFO into a local
// show-ahead buffer, tagging and counting misrouted packets.
module mesh_term_sink #(
  parameter int         pckg_sz    = 20,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] bdcst      = 8'hFF,
  parameter logic [3:0] TERM_ROW   = 4'd0,
  parameter logic [3:0] TERM_COL   = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [pckg_sz-1:0] rd_data,
  output logic               rd_misroute,
  output logic               full,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        err_cnt
);

  localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(fifo_depth);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    SETTLE
  } state_t;

  state_t state;

  logic [pckg_sz-1:0]    mem [fifo_depth];
  logic [fifo_depth-1:0] mis_mem;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;

  logic [7:0] dst;
  logic       is_local;
  logic       is_bcast;
  logic       is_mis;
  logic       wr;
  logic       rd;

  assign dst      = data_out[pckg_sz-9 -: 8];
  assign is_local = (dst == {TERM_ROW, TERM_COL});
  assign is_bcast = (dst == bdcst);
  assign is_mis   = !is_local && !is_bcast;

  // The capture happens on the edge that closes the pop cycle.
  assign wr = (state == POP);
  assign rd = rd_en && rd_valid;

  assign rd_valid    = (count != '0);
  assign full        = (count == DEPTH);
  assign rd_data     = rd_valid ? mem[rd_ptr] : '0;
  assign rd_misroute = rd_valid ? mis_mem[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pop   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pndng && !full) begin
            state <= POP;
            pop   <= 1'b1;
          end
        end
        POP: begin
          state <= SETTLE;
          pop   <= 1'b0;
        end
        SETTLE: begin
          state <= IDLE;
          pop   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          pop   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
        if (is_mis && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  end

  // Storage is not cleared; emptiness is carried by the pointers.
  always_ff @(posedge clk) begin
    if (reset && wr) begin
      mem[wr_ptr]     <= data_out;
      mis_mem[wr_ptr] <= is_mis;
    end
  end

endmodule

// File: tb/tb_mesh_term_sink.sv
// Bench for mesh_term_sink: router FIFO model feeding the sink,
// buffer/counter reference model kept as queues.
module tb_mesh_term_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [19:0] data_out;
  logic        pop;
  logic        rd_en;
  logic        rd_valid;
  logic [19:0] rd_data;
  logic        rd_misroute;
  logic        full;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  mesh_term_sink #(
    .pckg_sz(20),
    .fifo_depth(4),
    .bdcst(8'hFF),
    .TERM_ROW(4'd1),
    .TERM_COL(4'd2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pndng(pndng),
    .data_out(data_out),
    .pop(pop),
    .rd_en(rd_en),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_misroute(rd_misroute),
    .full(full),
    .pkt_cnt(pkt_cnt),
    .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [19:0] d;
    logic        m;
  } ent_t;

  logic [19:0] rq[$];
  ent_t        mq[$];
  int          exp_pkt = 0;
  int          exp_err = 0;
  int          ncmp = 0;
  int          nerr = 0;
  int          cyc = 0;

  function automatic logic mis_of(logic [19:0] p);
    logic [7:0] d;
    d = p[11:4];
    return !(d == 8'h12 || d == 8'hFF);
  endfunction

  function automatic logic [19:0] gen_pkt(int kind);
    logic [19:0] p;
    logic [7:0]  d;
    p = 20'($urandom);
    case (kind)
      0: d = 8'h12;
      1: d = 8'hFF;
      default: begin
        d = 8'($urandom);
        if (d == 8'h12 || d == 8'hFF) d = 8'h33;
      end
    endcase
    p[11:4] = d;
    return p;
  endfunction

  task automatic refresh();
    pndng = (rq.size() > 0);
    if (rq.size() > 0) data_out = rq[0];
    else data_out = 20'($urandom);
  endtask

  // One clock: router pops on a sampled pop, model tracks the buffer.
  task automatic step();
    logic p0, r0, rs0;
    ent_t e;
    p0  = (pop === 1'b1);
    rs0 = reset;
    r0  = rd_en && (mq.size() > 0);
    e.d = data_out;
    e.m = mis_of(data_out);
    @(posedge clk);
    #1;
    cyc++;
    if (!rs0) begin
      mq.delete();
      exp_pkt = 0;
      exp_err = 0;
    end else begin
      if (r0) void'(mq.pop_front());
      if (p0) begin
        mq.push_back(e);
        if (exp_pkt < 65535) exp_pkt++;
        if (e.m && exp_err < 65535) exp_err++;
      end
    end
    if (p0 && rq.size() > 0) void'(rq.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rd_en = 1'b0;
    rq.delete();
    refresh();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rd_en = 1'b0;
    rq.push_back(gen_pkt(0));
    refresh();
    step();
    step();
    ncmp++; if (pop !== 1'b0) begin nerr++; $display("FAIL rst_pop: got %b want 0", pop); end
    ncmp++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", rd_valid); end
    ncmp++; if (rd_misroute !== 1'b0) begin nerr++; $display("FAIL rst_mis: got %b want 0", rd_misroute); end
    ncmp++; if (full !== 1'b0) begin nerr++; $display("FAIL rst_full: got %b want 0", full); end
    ncmp++; if (pkt_cnt !== 16'd0) begin nerr++; $display("FAIL rst_pkt: got %h want 0", pkt_cnt); end
    ncmp++; if (err_cnt !== 16'd0) begin nerr++; $display("FAIL rst_err: got %h want 0", err_cnt); end
    ncmp++; if (rd_data !== 20'd0) begin nerr++; $display("FAIL rst_data: got %h want 0", rd_data); end
    rq.delete();
    refresh();
    reset = 1'b1;
  endtask

  task automatic test_local();
    do_reset();
    rq.push_back(20'h0012D);
    refresh();
    ncmp++; if (pop !== 1'b0) begin nerr++; $display("FAIL loc_pop_early: got %b want 0", pop); end
    step();
    ncmp++; if (pop !== 1'b1) begin nerr++; $display("FAIL loc_pop: got %b want 1", pop); end
    ncmp++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL loc_valid_early: got %b want 0", rd_valid); end
    step();
    ncmp++; if (pop !== 1'b0) begin nerr++; $display("FAIL loc_pop_len: got %b want 0", pop); end
    ncmp++; if (rd_valid !== 1'b1) begin nerr++; $display("FAIL loc_valid: got %b want 1", rd_valid); end
    ncmp++; if (rd_data !== 20'h0012D) begin nerr++; $display("FAIL loc_data: got %h want 0012d", rd_data); end
    ncmp++; if (rd_misroute !== 1'b0) begin nerr++; $display("FAIL loc_mis: got %b want 0", rd_misroute); end
    ncmp++; if (pkt_cnt !== 16'd1) begin nerr++; $display("FAIL loc_pkt: got %0d want 1", pkt_cnt); end
    ncmp++; if (err_cnt !== 16'd0) begin nerr++; $display("FAIL loc_err: got %0d want 0", err_cnt); end
    for (int i = 0; i < 4; i++) begin
      step();
      ncmp++; if (pop !== 1'b0) begin nerr++; $display("FAIL loc_extra_pop: got %b want 0", pop); end
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    ncmp++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL loc_drain: got %b want 0", rd_valid); end
  endtask

  task automatic test_bcast_mis();
    do_reset();
    rq.push_back(20'h00FF3);
    rq.push_back(20'h00005);
    refresh();
    step();
    step();
    ncmp++; if (rd_data !== 20'h00FF3) begin nerr++; $display("FAIL bm_data0: got %h want 00ff3", rd_data); end
    ncmp++; if (rd_misroute !== 1'b0) begin nerr++; $display("FAIL bm_mis0: got %b want 0", rd_misroute); end
    for (int i = 0; i < 4; i++) step();
    ncmp++; if (pkt_cnt !== 16'd2) begin nerr++; $display("FAIL bm_pkt: got %0d want 2", pkt_cnt); end
    ncmp++; if (err_cnt !== 16'd1) begin nerr++; $display("FAIL bm_err: got %0d want 1", err_cnt); end
    rd_en = 1'b1;
    step();
    ncmp++; if (rd_data !== 20'h00005) begin nerr++; $display("FAIL bm_data1: got %h want 00005", rd_data); end
    ncmp++; if (rd_misroute !== 1'b1) begin nerr++; $display("FAIL bm_mis1: got %b want 1", rd_misroute); end
    step();
    rd_en = 1'b0;
    ncmp++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL bm_drain: got %b want 0", rd_valid); end
  endtask

  task automatic test_backpressure();
    logic [19:0] sent[$];
    logic [19:0] got[$];
    int pc[$];
    int n5;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sent.push_back(gen_pkt($urandom_range(0, 2)));
      rq.push_back(sent[i]);
    end
    refresh();
    for (int i = 0; i < 24; i++) begin
      step();
      if (pop === 1'b1) pc.push_back(cyc);
    end
    ncmp++; if (pc.size() != 4) begin nerr++; $display("FAIL bp_pops: got %0d want 4", pc.size()); end
    for (int k = 1; k < 4; k++) begin
      if (k < pc.size()) begin
        ncmp++; if (pc[k] - pc[k-1] != 3) begin nerr++; $display("FAIL bp_space: got %0d want 3", pc[k] - pc[k-1]); end
      end
    end
    ncmp++; if (full !== 1'b1) begin nerr++; $display("FAIL bp_full: got %b want 1", full); end
    ncmp++; if (rd_data !== sent[0]) begin nerr++; $display("FAIL bp_head: got %h want %h", rd_data, sent[0]); end
    rd_en = 1'b1;
    got.push_back(rd_data);
    step();
    rd_en = 1'b0;
    ncmp++; if (full !== 1'b0) begin nerr++; $display("FAIL bp_unfull: got %b want 0", full); end
    n5 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pop === 1'b1) n5++;
    end
    ncmp++; if (n5 != 1) begin nerr++; $display("FAIL bp_pop5: got %0d want 1", n5); end
    ncmp++; if (full !== 1'b1) begin nerr++; $display("FAIL bp_refull: got %b want 1", full); end
    rd_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (rd_valid === 1'b1) got.push_back(rd_data);
      step();
    end
    rd_en = 1'b0;
    ncmp++; if (got.size() != 6) begin nerr++; $display("FAIL bp_cnt: got %0d want 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        ncmp++; if (got[i] !== sent[i]) begin nerr++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], sent[i]); end
      end
    end
  endtask

  task automatic test_stream();
    logic [19:0] sent[$];
    logic [19:0] got[$];
    int nmis;
    ent_t h;
    do_reset();
    nmis = 0;
    for (int i = 0; i < 8; i++) begin
      sent.push_back(gen_pkt($urandom_range(0, 2)));
      rq.push_back(sent[i]);
      if (mis_of(sent[i])) nmis++;
    end
    refresh();
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (rd_valid === 1'b1) got.push_back(rd_data);
      step();
      h = (mq.size() > 0) ? mq[0] : '0;
      ncmp++; if (rd_valid !== (mq.size() > 0)) begin nerr++; $display("FAIL st_valid@%0d: got %b want %b", cyc, rd_valid, mq.size() > 0); end
      ncmp++; if (rd_data !== h.d) begin nerr++; $display("FAIL st_data@%0d: got %h want %h", cyc, rd_data, h.d); end
      ncmp++; if (rd_misroute !== h.m) begin nerr++; $display("FAIL st_mis@%0d: got %b want %b", cyc, rd_misroute, h.m); end
      ncmp++; if (mq.size() > 1) begin nerr++; $display("FAIL st_occ@%0d: got %0d want <=1", cyc, mq.size()); end
    end
    rd_en = 1'b0;
    ncmp++; if (got.size() != 8) begin nerr++; $display("FAIL st_cnt: got %0d want 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        ncmp++; if (got[i] !== sent[i]) begin nerr++; $display("FAIL st_order[%0d]: got %h want %h", i, got[i], sent[i]); end
      end
    end
    ncmp++; if (pkt_cnt !== 16'd8) begin nerr++; $display("FAIL st_pkt: got %0d want 8", pkt_cnt); end
    ncmp++; if (err_cnt !== 16'(nmis)) begin nerr++; $display("FAIL st_err: got %0d want %0d", err_cnt, nmis); end
  endtask

  task automatic test_reset_mid();
    logic [19:0] p2;
    int k;
    do_reset();
    rq.push_back(gen_pkt(0));
    refresh();
    k = 0;
    while (pop !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    ncmp++; if (pop !== 1'b1) begin nerr++; $display("FAIL rm_wait_pop: got %b want 1", pop); end
    reset = 1'b0;
    step();
    ncmp++; if (pop !== 1'b0) begin nerr++; $display("FAIL rm_pop: got %b want 0", pop); end
    ncmp++; if (pkt_cnt !== 16'd0) begin nerr++; $display("FAIL rm_pkt: got %0d want 0", pkt_cnt); end
    ncmp++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL rm_valid: got %b want 0", rd_valid); end
    reset = 1'b1;
    p2 = gen_pkt(2);
    rq.push_back(p2);
    refresh();
    for (int i = 0; i < 4; i++) step();
    ncmp++; if (rd_valid !== 1'b1) begin nerr++; $display("FAIL rm_resume_valid: got %b want 1", rd_valid); end
    ncmp++; if (rd_data !== p2) begin nerr++; $display("FAIL rm_resume_data: got %h want %h", rd_data, p2); end
    ncmp++; if (pkt_cnt !== 16'd1) begin nerr++; $display("FAIL rm_resume_pkt: got %0d want 1", pkt_cnt); end
    ncmp++; if (err_cnt !== 16'd1) begin nerr++; $display("FAIL rm_resume_err: got %0d want 1", err_cnt); end
  endtask

  task automatic test_random();
    logic prev_pop;
    ent_t h;
    do_reset();
    prev_pop = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && rq.size() < 8) begin
        rq.push_back(gen_pkt($urandom_range(0, 2)));
        refresh();
      end
      rd_en = ($urandom_range(0, 3) == 0);
      step();
      h = (mq.size() > 0) ? mq[0] : '0;
      ncmp++; if (rd_valid !== (mq.size() > 0)) begin nerr++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, rd_valid, mq.size() > 0); end
      ncmp++; if (rd_data !== h.d) begin nerr++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, rd_data, h.d); end
      ncmp++; if (rd_misroute !== h.m) begin nerr++; $display("FAIL rnd_mis@%0d: got %b want %b", cyc, rd_misroute, h.m); end
      ncmp++; if (full !== (mq.size() == 4)) begin nerr++; $display("FAIL rnd_full@%0d: got %b want %b", cyc, full, mq.size() == 4); end
      ncmp++; if (pkt_cnt !== 16'(exp_pkt)) begin nerr++; $display("FAIL rnd_pkt@%0d: got %0d want %0d", cyc, pkt_cnt, exp_pkt); end
      ncmp++; if (err_cnt !== 16'(exp_err)) begin nerr++; $display("FAIL rnd_err@%0d: got %0d want %0d", cyc, err_cnt, exp_err); end
      ncmp++; if (pop === 1'b1 && prev_pop) begin nerr++; $display("FAIL rnd_pop_b2b@%0d: got 1 want 0", cyc); end
      prev_pop = (pop === 1'b1);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    rd_en    = 1'b0;
    pndng    = 1'b0;
    data_out = 20'd0;
    test_reset();
    test_local();
    test_bcast_mis();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mesh_term_sink.md
MESH_TERM_SINK -- requirements
Module: mesh_term_sink

Interface
REQ-001 SHALL have parameter pckg_sz, default 20: packet width in bits.
REQ-002 SHALL have parameter fifo_depth, default 4: local receive buffer depth (power of two, >=2).
REQ-003 SHALL have parameter bdcst, default 8'hFF: broadcast destination id value.
REQ-004 SHALL have parameter TERM_ROW, default 0: own row id (4 bits).
REQ-005 SHALL have parameter TERM_COL, default 0: own column id (4 bits).
REQ-006 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have port pndng  input  1  router terminal output FIFO non-empty.
REQ-009 SHALL have port data_out  input  pckg_sz  router terminal head packet.
REQ-010 SHALL have port pop  output  1  one-cycle pop strobe to the router terminal FIFO.
REQ-011 SHALL have port rd_en  input  1  consumer read strobe.
REQ-012 SHALL have port rd_valid  output  1  buffer head valid.
REQ-013 SHALL have port rd_data  output  pckg_sz  buffer head packet.
REQ-014 SHALL have port rd_misroute  output  1  head packet was not addressed here.
REQ-015 SHALL have port full  output  1  buffer holds fifo_depth entries.
REQ-016 SHALL have port pkt_cnt  output  16  accepted-packet count, saturating at 16'hFFFF.
REQ-017 SHALL have port err_cnt  output  16  misrouted-packet count, saturating at 16'hFFFF.

Function
REQ-018 Packet fields SHALL be: [pckg_sz-1:pckg_sz-8] Nxt_jump, [pckg_sz-9:pckg_sz-12] id_row, [pckg_sz-13:pckg_sz-16] id_colum, [pckg_sz-17] mode, remaining low bits payload.
REQ-019 The FSM SHALL have three states: IDLE, POP, SETTLE.
REQ-020 IDLE -> POP SHALL occur when pndng=1 and full=0; otherwise the FSM stays in IDLE.
REQ-021 In POP, pop SHALL be 1 for exactly that cycle.
- data_out SHALL be written to the buffer, with its misroute flag, at the clock edge ending POP.
- The FSM SHALL then go to SETTLE.
REQ-022 SETTLE SHALL last one cycle with pop=0, then return to IDLE so the router's pndng can update.
- Consequence: at most one pop per 3 cycles.
- pop SHALL never be high in consecutive cycles.
REQ-023 Latency SHALL be exactly 2 clocks from pndng sampled high in IDLE to rd_valid=1 for that packet when the buffer was empty.
REQ-024 Destination classification of a captured packet:
- {id_row,id_colum} = {TERM_ROW,TERM_COL}: local.
- {id_row,id_colum} = bdcst: broadcast.
- Anything else: misroute.
REQ-025 Every captured packet SHALL increment pkt_cnt; misroutes SHALL also increment err_cnt; both counters saturate without wrap.
REQ-026 Misrouted packets SHALL still be buffered, with rd_misroute=1 when at the head.
REQ-027 The buffer SHALL be show-ahead.
- rd_valid = not empty; rd_data and rd_misroute reflect the head.
- rd_en with rd_valid=1 removes the head at the clock edge.
- rd_en with rd_valid=0 SHALL be ignored.
REQ-028 A write (end of POP) and a read in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-029 full SHALL be sampled only in IDLE; no write SHALL ever occur while full.
REQ-030 Read/write pointers SHALL wrap modulo fifo_depth.

Reset
REQ-031 While reset=0 at a clock edge, the block SHALL return to the reset state.
- State: IDLE.
- Outputs: pop=0, rd_valid=0, rd_misroute=0, full=0, pkt_cnt=0, err_cnt=0, rd_data=0.
- Buffer: emptied.
REQ-032 Reset asserted during POP SHALL discard the packet being captured and SHALL NOT count it.
- pop is low from the first reset edge.
REQ-033 After reset deasserts, the first pop SHALL occur no earlier than 1 cycle after pndng is sampled high in IDLE.

Verification (pckg_sz=20, TERM_ROW=1, TERM_COL=2, fifo_depth=4)
REQ-034 Local packet: pndng=1, data_out=20'h0012D, one packet available.
- Expect: a single 1-cycle pop.
- Expect: rd_valid=1 2 clocks later, rd_data=20'h0012D, rd_misroute=0, pkt_cnt=1, err_cnt=0.
REQ-035 Broadcast then misroute: 20'h00FF3, then 20'h00005.
- Expect: rd_misroute 0 then 1; pkt_cnt=2, err_cnt=1.
REQ-036 Backpressure: pndng held 1 with rd_en=0 and 6 packets.
- Expect: exactly 4 pops spaced 3 cycles apart, full=1, no 5th pop.
- One rd_en pulse -> full=0, a 5th pop follows.
REQ-037 Concurrent traffic: rd_en=1 continuously with a stream of 8 packets.
- Expect: FIFO order preserved, occupancy never exceeds 1, no rd_en effect while rd_valid=0.
REQ-038 Reset mid-capture: reset=0 asserted in the POP cycle.
- Expect: pop=0 next cycle, pkt_cnt=0, rd_valid=0.
- Expect: normal capture resumes after release.
